rtc_regfile_sequencer: RTL and testbench

//   Sole master of the 16x8 RTC register file. Advances the time fields (sec/min/hour/day) by

---
 rtl/rtc_pkg.sv | 56 +++++
 rtl/rtc_field_incr.sv | 45 ++++
 rtl/rtc_regfile_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_rtc_regfile_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC register-file sequencer.
// Build option: define RTC_BCD_EN for packed-BCD time fields; binary otherwise.
package rtc_pkg;

    // FSM encoding (plain constants so older tools and netlists stay readable)
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE       = 3'd0;
    localparam state_t ST_HOST_RD    = 3'd1;
    localparam state_t ST_HOST_RWAIT = 3'd2;
    localparam state_t ST_HOST_WR    = 3'd3;
    localparam state_t ST_UPD_RD     = 3'd4;
    localparam state_t ST_UPD_RWAIT  = 3'd5;
    localparam state_t ST_UPD_WR     = 3'd6;

    // Time fields in carry order: sec -> min -> hour -> day
    typedef logic [1:0] field_idx_t;
    localparam field_idx_t FIELD_SEC  = 2'd0;
    localparam field_idx_t FIELD_MIN  = 2'd1;
    localparam field_idx_t FIELD_HOUR = 2'd2;
    localparam field_idx_t FIELD_DAY  = 2'd3;
    localparam int         NUM_FIELDS = 4;

    // Binary limits: a field wraps when value+1 reaches the limit
    localparam logic [15:0] BIN_LIMIT_SEC  = 16'd60;
    localparam logic [15:0] BIN_LIMIT_MIN  = 16'd60;
    localparam logic [15:0] BIN_LIMIT_HOUR = 16'd24;
    localparam logic [15:0] BIN_LIMIT_DAY  = 16'd256;

    // BCD limits are the largest legal value: a field wraps once it is at or above it
    localparam logic [15:0] BCD_LIMIT_SEC  = 16'h0059;
    localparam logic [15:0] BCD_LIMIT_MIN  = 16'h0059;
    localparam logic [15:0] BCD_LIMIT_HOUR = 16'h0023;
    localparam logic [15:0] BCD_LIMIT_DAY  = 16'h0099;

    // Limit of a given field for the selected number format
    function automatic logic [15:0] field_limit(input field_idx_t f);
        logic [15:0] lim;
`ifdef RTC_BCD_EN
        case (f)
            FIELD_SEC:  lim = BCD_LIMIT_SEC;
            FIELD_MIN:  lim = BCD_LIMIT_MIN;
            FIELD_HOUR: lim = BCD_LIMIT_HOUR;
            default:    lim = BCD_LIMIT_DAY;
        endcase
`else
        case (f)
            FIELD_SEC:  lim = BIN_LIMIT_SEC;
            FIELD_MIN:  lim = BIN_LIMIT_MIN;
            FIELD_HOUR: lim = BIN_LIMIT_HOUR;
            default:    lim = BIN_LIMIT_DAY;
        endcase
`endif
        return lim;
    endfunction

endpackage

// File: rtl/rtc_field_incr.sv
// Combinational increment of one time field with wrap and carry-out.
// Build option: RTC_BCD_EN selects packed-BCD arithmetic; binary otherwise.
// Out-of-range inputs (e.g. a host-written 75 seconds) wrap to 0 with carry.
module rtc_field_incr
    import rtc_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] v,
    input  logic [DATA_W:0]   limit,
    output logic [DATA_W-1:0] next_v,
    output logic              carry
);

`ifdef RTC_BCD_EN
    // BCD: wrap at/above the maximum, otherwise decimal-adjust the low nibble
    always_comb begin
        next_v = v;
        carry  = 1'b0;
        if ({1'b0, v} >= limit) begin
            next_v = '0;
            carry  = 1'b1;
        end else if (v[3:0] >= 4'd9) begin
            next_v[3:0]        = 4'd0;
            next_v[DATA_W-1:4] = v[DATA_W-1:4] + (DATA_W-4)'(1);
        end else begin
            next_v[3:0] = v[3:0] + 4'd1;
        end
    end
`else
    logic [DATA_W:0] v_inc;

    // Binary: widened add so the 2^DATA_W day limit is representable
    always_comb begin
        v_inc  = {1'b0, v} + (DATA_W+1)'(1);
        next_v = v_inc[DATA_W-1:0];
        carry  = 1'b0;
        if (v_inc >= limit) begin
            next_v = '0;
            carry  = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/rtc_regfile_sequencer.sv
// Sole master of the RTC register file: runs the once-per-second
// read-modify-write carry chain over sec/min/hour/day and serialises host
// reads/writes into the same file, one operation in flight at a time.
// Build option: RTC_BCD_EN switches the time fields to packed BCD.
module rtc_regfile_sequencer
    import rtc_pkg::*;
#(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int SEC_ADDR  = 0,
    parameter int MIN_ADDR  = 1,
    parameter int HOUR_ADDR = 2,
    parameter int DAY_ADDR  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_1hz,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data_in,
    output logic              rf_write_en,
    output logic              rf_read_en,
    input  logic [DATA_W-1:0] rf_data_out,
    output logic              busy,
    output logic              tick_overrun,
    input  logic              ovr_clr
);

    localparam int FIELD_ADDRS [NUM_FIELDS] = '{SEC_ADDR, MIN_ADDR, HOUR_ADDR, DAY_ADDR};

    // Per-field address and limit lookup tables
    logic [ADDR_W-1:0] field_addr_tbl  [NUM_FIELDS];
    logic [DATA_W:0]   field_limit_tbl [NUM_FIELDS];

    for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_field_tbl
        assign field_addr_tbl[gi]  = ADDR_W'(FIELD_ADDRS[gi]);
        assign field_limit_tbl[gi] = (DATA_W+1)'(field_limit(field_idx_t'(gi)));
    end

    state_t            state_q,        state_d;
    field_idx_t        field_q,        field_d;
    logic              carry_q,        carry_d;
    logic              tick_pend_q,    tick_pend_d;
    logic              overrun_q,      overrun_d;
    logic              host_ack_q,     host_ack_d;
    logic [DATA_W-1:0] host_rdata_q,   host_rdata_d;
    logic [ADDR_W-1:0] rf_addr_q,      rf_addr_d;
    logic [DATA_W-1:0] rf_data_in_q,   rf_data_in_d;
    logic              rf_write_en_q,  rf_write_en_d;
    logic              rf_read_en_q,   rf_read_en_d;
    logic              busy_q,         busy_d;

    logic [DATA_W-1:0] incr_val;
    logic              incr_carry;
    field_idx_t        field_nxt;

    assign field_nxt = field_q + 2'd1;

    rtc_field_incr #(
        .DATA_W (DATA_W)
    ) u_incr (
        .v      (rf_data_out),
        .limit  (field_limit_tbl[field_q]),
        .next_v (incr_val),
        .carry  (incr_carry)
    );

    // Next-state logic: FSM, tick bookkeeping and registered strobes
    always_comb begin
        state_d       = state_q;
        field_d       = field_q;
        carry_d       = carry_q;
        tick_pend_d   = tick_pend_q;
        host_ack_d    = 1'b0;
        host_rdata_d  = host_rdata_q;
        rf_addr_d     = rf_addr_q;
        rf_data_in_d  = rf_data_in_q;
        rf_write_en_d = 1'b0;
        rf_read_en_d  = 1'b0;

        // A tick while one is already waiting is dropped and flagged;
        // the clear request always beats a same-cycle overrun.
        if (tick_1hz && !tick_pend_q) begin
            tick_pend_d = 1'b1;
        end
        if (ovr_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q | (tick_1hz & tick_pend_q);
        end

        case (state_q)
            ST_IDLE: begin
                if (tick_pend_q || tick_1hz) begin
                    state_d      = ST_UPD_RD;
                    field_d      = FIELD_SEC;
                    rf_addr_d    = field_addr_tbl[FIELD_SEC];
                    rf_read_en_d = 1'b1;
                    tick_pend_d  = 1'b0;
                end else if (host_req && !host_ack_q) begin
                    // host_req is still high in the cycle our ack is visible,
                    // so that cycle must not be taken as a fresh request
                    rf_addr_d = host_addr;
                    if (host_we) begin
                        state_d       = ST_HOST_WR;
                        rf_data_in_d  = host_wdata;
                        rf_write_en_d = 1'b1;
                        host_ack_d    = 1'b1;
                    end else begin
                        state_d      = ST_HOST_RD;
                        rf_read_en_d = 1'b1;
                    end
                end
            end
            ST_HOST_RD: begin
                state_d = ST_HOST_RWAIT;
            end
            ST_HOST_RWAIT: begin
                host_rdata_d = rf_data_out;
                host_ack_d   = 1'b1;
                state_d      = ST_IDLE;
            end
            ST_HOST_WR: begin
                state_d = ST_IDLE;
            end
            ST_UPD_RD: begin
                state_d = ST_UPD_RWAIT;
            end
            ST_UPD_RWAIT: begin
                rf_data_in_d  = incr_val;
                rf_write_en_d = 1'b1;
                carry_d       = incr_carry;
                state_d       = ST_UPD_WR;
            end
            ST_UPD_WR: begin
                // The day counter wraps silently; nothing sits above it
                if (carry_q && field_q != FIELD_DAY) begin
                    field_d      = field_nxt;
                    rf_addr_d    = field_addr_tbl[field_nxt];
                    rf_read_en_d = 1'b1;
                    state_d      = ST_UPD_RD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            field_q       <= FIELD_SEC;
            carry_q       <= 1'b0;
            tick_pend_q   <= 1'b0;
            overrun_q     <= 1'b0;
            host_ack_q    <= 1'b0;
            host_rdata_q  <= '0;
            rf_addr_q     <= '0;
            rf_data_in_q  <= '0;
            rf_write_en_q <= 1'b0;
            rf_read_en_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            field_q       <= field_d;
            carry_q       <= carry_d;
            tick_pend_q   <= tick_pend_d;
            overrun_q     <= overrun_d;
            host_ack_q    <= host_ack_d;
            host_rdata_q  <= host_rdata_d;
            rf_addr_q     <= rf_addr_d;
            rf_data_in_q  <= rf_data_in_d;
            rf_write_en_q <= rf_write_en_d;
            rf_read_en_q  <= rf_read_en_d;
            busy_q        <= busy_d;
        end
    end

    assign host_ack     = host_ack_q;
    assign host_rdata   = host_rdata_q;
    assign rf_addr      = rf_addr_q;
    assign rf_data_in   = rf_data_in_q;
    assign rf_write_en  = rf_write_en_q;
    assign rf_read_en   = rf_read_en_q;
    assign busy         = busy_q;
    assign tick_overrun = overrun_q;

endmodule

// File: tb/tb_rtc_regfile_sequencer.sv
// Bench for rtc_regfile_sequencer: models the 16x8 register file, queues the
// expected host read data on issue and compares it in a monitor on host_ack.
// Build option: RTC_BCD_EN selects BCD-coded stimulus values.
`timescale 1ns/1ps
module tb_rtc_regfile_sequencer;

`ifdef RTC_BCD_EN
    localparam logic [7:0] V10 = 8'h10, V11 = 8'h11, V23 = 8'h23, V59 = 8'h59, V75 = 8'h75;
`else
    localparam logic [7:0] V10 = 8'd10, V11 = 8'd11, V23 = 8'd23, V59 = 8'd59, V75 = 8'd75;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       host_req = 1'b0;
    logic       host_we = 1'b0;
    logic [3:0] host_addr = 4'd0;
    logic [7:0] host_wdata = 8'd0;
    logic       ovr_clr = 1'b0;
    logic       host_ack;
    logic [7:0] host_rdata;
    logic [3:0] rf_addr;
    logic [7:0] rf_data_in;
    logic       rf_write_en;
    logic       rf_read_en;
    logic [7:0] rf_data_out;
    logic       busy;
    logic       tick_overrun;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    rtc_regfile_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .tick_1hz     (tick_1hz),
        .host_req     (host_req),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_ack     (host_ack),
        .host_rdata   (host_rdata),
        .rf_addr      (rf_addr),
        .rf_data_in   (rf_data_in),
        .rf_write_en  (rf_write_en),
        .rf_read_en   (rf_read_en),
        .rf_data_out  (rf_data_out),
        .busy         (busy),
        .tick_overrun (tick_overrun),
        .ovr_clr      (ovr_clr)
    );

    // Register file model: synchronous write, registered read
    logic [7:0] rf_mem [16];
    always @(posedge clk) begin
        if (rf_write_en) rf_mem[rf_addr] <= rf_data_in;
        if (rf_read_en)  rf_data_out <= rf_mem[rf_addr];
    end

    // Scoreboard
    typedef struct {
        logic       is_read;
        logic [3:0] addr;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (!rst && host_ack) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_ack: got ack with rdata=%h, required no ack", host_rdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.is_read) begin
                    n_checks++;
                    if (host_rdata === mon_e.data) begin
                        n_pass++;
                        $display("read  addr=%0d data=%h", mon_e.addr, host_rdata);
                    end else begin
                        $display("FAIL read_addr%0d: got %h, required %h", mon_e.addr, host_rdata, mon_e.data);
                    end
                end else begin
                    $display("write addr=%0d data=%h", mon_e.addr, mon_e.data);
                end
            end
        end
    end

    // Register-file strobes must never be active together
    always @(negedge clk) begin
        if (!rst && (rf_read_en || rf_write_en)) begin
            n_checks++;
            if (!(rf_read_en && rf_write_en)) n_pass++;
            else $display("FAIL strobe_excl: got read_en=1 write_en=1, required at most one");
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, got, want);
    endtask

    task automatic host_access(input logic we, input logic [3:0] a, input logic [7:0] d,
                               input logic [7:0] exp_rd, input logic with_tick,
                               output int busy_cyc);
        exp_t e;
        bit got;
        e.is_read = !we;
        e.addr    = a;
        e.data    = we ? d : exp_rd;
        exp_q.push_back(e);
        @(posedge clk); #1;
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = a;
        host_wdata = d;
        if (with_tick) tick_1hz = 1'b1;
        busy_cyc = 0;
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (n == 1) tick_1hz = 1'b0;
            if (busy) busy_cyc++;
            if (host_ack) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            $display("FAIL ack_timeout_addr%0d: got no ack, required ack within 100 cycles", a);
        end
        @(posedge clk); #1;
        host_req = 1'b0;
        tick_1hz = 1'b0;
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        int bc;
        host_access(1'b1, a, d, 8'h00, 1'b0, bc);
    endtask

    task automatic host_read(input logic [3:0] a, input logic [7:0] exp_rd);
        int bc;
        host_access(1'b0, a, 8'h00, exp_rd, 1'b0, bc);
    endtask

    // Hold tick high for n cycles (n>1 deliberately overlaps ticks); optionally clear overrun on the last
    task automatic tick_burst(input int n, input logic clr_last);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            tick_1hz = 1'b1;
            ovr_clr  = clr_last && (i == n - 1);
        end
        @(posedge clk); #1;
        tick_1hz = 1'b0;
        ovr_clr  = 1'b0;
    endtask

    // Single tick, then count busy cycles of the update it starts
    task automatic tick_and_count(output int cyc);
        tick_burst(1, 1'b0);
        cyc = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (busy) cyc++;
            else break;
        end
    endtask

    task automatic wait_idle(input string name);
        int run;
        run = 0;
        for (int n = 0; n < 300 && run < 3; n++) begin
            @(negedge clk);
            if (!busy) run++;
            else run = 0;
        end
        if (run < 3) begin
            n_checks++;
            $display("FAIL %s: got busy still high, required idle within 300 cycles", name);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, required finish within 2 ms");
        $fatal(1, "bench timeout");
    end

    initial begin
        int bc;

        // Reset values
        @(negedge clk);
        check("reset_outputs",
              {host_ack, host_rdata, rf_addr, rf_data_in, rf_write_en, rf_read_en, busy, tick_overrun},
              32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: host write then read back; write occupies one HOST_WR cycle
        host_access(1'b1, 4'd5, 8'h2A, 8'h00, 1'b0, bc);
        check("write_busy_cycles", bc, 1);
        host_access(1'b0, 4'd5, 8'h00, 8'h2A, 1'b0, bc);
        check("read_busy_cycles", bc, 2);

        // 2: single-field update
        host_write(4'd0, V10);
        host_write(4'd1, 8'h00);
        tick_and_count(bc);
        check("tick_no_carry_busy", bc, 3);
        host_read(4'd0, V11);
        host_read(4'd1, 8'h00);

        // 3: full carry chain
        host_write(4'd0, V59);
        host_write(4'd1, V59);
        host_write(4'd2, V23);
        host_write(4'd3, 8'h07);
        tick_and_count(bc);
        check("tick_full_carry_busy", bc, 12);
        host_read(4'd0, 8'h00);
        host_read(4'd1, 8'h00);
        host_read(4'd2, 8'h00);
        host_read(4'd3, 8'h08);

        // 4: read and tick together -> update first, read sees new value
        host_access(1'b0, 4'd0, 8'h00, 8'h01, 1'b1, bc);
        check("tick_then_read_busy", bc, 5);

        // 5: overlapping ticks during a carry chain
        host_write(4'd0, V59);
        host_write(4'd1, V59);
        host_write(4'd2, V23);
        tick_burst(3, 1'b0);
        check("overrun_set", tick_overrun, 1'b1);
        wait_idle("idle_after_pending");
        host_read(4'd0, 8'h01);
        host_read(4'd1, 8'h00);
        host_read(4'd2, 8'h00);
        host_read(4'd3, 8'h09);
        check("overrun_sticky", tick_overrun, 1'b1);
        @(posedge clk); #1;
        ovr_clr = 1'b1;
        @(posedge clk); #1;
        ovr_clr = 1'b0;
        check("overrun_cleared", tick_overrun, 1'b0);
        tick_burst(3, 1'b1);
        check("overrun_clr_wins", tick_overrun, 1'b0);
        wait_idle("idle_after_clr");
        host_read(4'd0, 8'h03);

        // 6: out-of-range seconds wrap with carry
        host_write(4'd0, V75);
        tick_burst(1, 1'b0);
        wait_idle("idle_after_oor");
        host_read(4'd0, 8'h00);
        host_read(4'd1, 8'h01);

        // 6b: reset during UPD_RWAIT aborts without writing
        host_write(4'd0, 8'h05);
        tick_burst(1, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midupdate_reset_outputs",
              {host_ack, host_rdata, rf_addr, rf_data_in, rf_write_en, rf_read_en, busy, tick_overrun},
              32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        bc = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (busy) bc++;
        end
        check("no_pending_after_reset", bc, 0);
        host_read(4'd0, 8'h05);

        repeat (4) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
